// File: rtl/fifo_mem_writer.sv
// ---------------------------------------------------------------------------
// fifo_mem_writer
//
// Pops bytes from a FIFO read port, packs four of them little-endian into a
// 32-bit word and issues that word as a valid/ready memory write. Successive
// words go to successive word addresses. After the top address the next word
// goes to BASE_ADDR.
//
// Optional feature (compile-time macro PARITY_EN): adds mem_parity[3:0].
// Bit i is the even-parity bit (XOR) of byte i of mem_wdata, and it is
// registered together with mem_wdata.
//
// Ports
//   clk_mem        in   the only clock; all state changes on its rising edge
//   reset          in   synchronous active-high reset
//   enable         in   permits new byte pops; a pending write always completes
//   empty          in   FIFO empty flag
//   data_in[7:0]   in   FIFO read data, valid while rd_en_mem=1
//   rd_en_mem      out  FIFO pop strobe (combinational)
//   mem_wr_valid   out  memory write request
//   mem_wr_ready   in   memory accepts the request on valid & ready
//   mem_addr       out  word address of the pending write
//   mem_wdata      out  assembled word
//   busy           out  partial word held or write pending
//   words_written  out  count of accepted writes (16-bit, wraps)
//   mem_parity     out  per-byte parity of mem_wdata (PARITY_EN only)
// ---------------------------------------------------------------------------
module fifo_mem_writer #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk_mem,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [7:0]            data_in,
    output logic                  rd_en_mem,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic [15:0]           words_written
`ifdef PARITY_EN
    ,
    output logic [3:0]            mem_parity
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        WRITE   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           count_q, count_d;
    logic [3:0]            lane_wr;
    logic                  pop;
    logic                  handshake;

    // Reset is folded in so the FIFO is never popped during a reset cycle.
    assign pop       = (state_q == COLLECT) & enable & ~empty & ~reset;
    assign handshake = (state_q == WRITE) & mem_wr_ready;

    // One write strobe per byte lane. Only the lane selected by byte_cnt is
    // loaded, so partial lanes keep their bytes while collection is paused.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_wr[gi]             = pop & (byte_cnt_q == 2'(gi));
            assign wdata_d[8*gi +: 8]      = lane_wr[gi] ? data_in : wdata_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        count_d    = count_q;
        if (pop) begin
            // The 2-bit counter rolls 3->0 as the last lane is filled.
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                state_d = WRITE;
            end
        end
        if (handshake) begin
            state_d = COLLECT;
            count_d = count_q + 16'd1;
            if (addr_q == {ADDR_WIDTH{1'b1}}) begin
                addr_d = BASE_ADDR;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_mem) begin
        if (reset) begin
            state_q    <= COLLECT;
            byte_cnt_q <= 2'd0;
            wdata_q    <= 32'd0;
            addr_q     <= BASE_ADDR;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
        end
    end

`ifdef PARITY_EN
    logic [3:0] parity_q, parity_d;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_par
            assign parity_d[gi] = lane_wr[gi] ? ^data_in : parity_q[gi];
        end
    endgenerate

    always_ff @(posedge clk_mem) begin
        if (reset) begin
            parity_q <= 4'd0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign mem_parity = parity_q;
`endif

    assign rd_en_mem     = pop;
    assign mem_wr_valid  = (state_q == WRITE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign busy          = (byte_cnt_q != 2'd0) | (state_q == WRITE);
    assign words_written = count_q;

endmodule

// File: tb/tb_fifo_mem_writer.sv
// ---------------------------------------------------------------------------
// tb_fifo_mem_writer
//
// Directed bench for fifo_mem_writer (ADDR_WIDTH=2, BASE_ADDR=0).
// A queue models the FIFO. A byte-level reference model is compared against
// every output on each falling edge. Literal expectations on the logged
// writes pin the model itself. The bench prints one line per accepted write.
// ---------------------------------------------------------------------------
module tb_fifo_mem_writer;

    localparam int AW   = 2;
    localparam int BASE = 0;

    logic          clk_mem = 1'b0;
    logic          reset;
    logic          enable;
    logic          empty;
    logic [7:0]    data_in;
    logic          rd_en_mem;
    logic          mem_wr_valid;
    logic          mem_wr_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic [15:0]   words_written;
`ifdef PARITY_EN
    logic [3:0]    mem_parity;
`endif

    fifo_mem_writer #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (AW'(BASE))
    ) dut (
        .clk_mem       (clk_mem),
        .reset         (reset),
        .enable        (enable),
        .empty         (empty),
        .data_in       (data_in),
        .rd_en_mem     (rd_en_mem),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_ready  (mem_wr_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .words_written (words_written)
`ifdef PARITY_EN
        ,
        .mem_parity    (mem_parity)
`endif
    );

    always #5 clk_mem = ~clk_mem;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO source ----------------
    logic [7:0] src_q[$];
    logic       hold_empty;
    logic       pop_pending = 1'b0;

    task automatic apply_src();
        empty   = hold_empty || (src_q.size() == 0);
        data_in = (src_q.size() != 0) ? src_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        src_q.push_back(b);
        apply_src();
    endtask

    task automatic tick();
        @(posedge clk_mem);
        #1;
        if (pop_pending) begin
            void'(src_q.pop_front());
            pop_pending = 1'b0;
        end
        apply_src();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !mem_wr_valid; i++) tick();
        chk("wait_valid", 32'(mem_wr_valid), 32'd1);
    endtask

    // ---------------- reference model ----------------
    // The model holds the bytes taken so far, the number of filled lanes,
    // a pending-write flag, the next address and the write count.
    logic [7:0] m_byte [4];
    int         m_n       = 0;
    bit         m_pending = 0;
    int         m_addr    = BASE;
    int         m_cnt     = 0;

    // Writes actually accepted by the DUT, in order.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [3:0]  obs_par[$];

    initial begin
        for (int i = 0; i < 4; i++) m_byte[i] = 8'h00;
    end

    always @(negedge clk_mem) begin
        logic [31:0] m_word;
        logic [3:0]  m_par;
        bit          exp_rd;
        m_word = {m_byte[3], m_byte[2], m_byte[1], m_byte[0]};
        for (int i = 0; i < 4; i++) m_par[i] = ^m_byte[i];
        exp_rd = !reset && !m_pending && enable && !empty;

        chk("rd_en_mem", 32'(rd_en_mem), 32'(exp_rd));
        chk("mem_wr_valid", 32'(mem_wr_valid), 32'(m_pending));
        chk("busy", 32'(busy), 32'((m_n != 0) || m_pending));
        chk("words_written", 32'(words_written), 32'(m_cnt[15:0]));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", mem_wdata, m_word);
`ifdef PARITY_EN
        chk("mem_parity", 32'(mem_parity), 32'(m_par));
`endif

        if (!reset && mem_wr_valid && mem_wr_ready) begin
            obs_addr.push_back(32'(mem_addr));
            obs_data.push_back(mem_wdata);
`ifdef PARITY_EN
            obs_par.push_back(mem_parity);
`else
            obs_par.push_back(m_par);
`endif
            $display("write #%0d: addr=%0d wdata=%08h", obs_data.size(), mem_addr, mem_wdata);
        end

        // Advance the model to the state after the coming rising edge.
        if (reset) begin
            m_n = 0; m_pending = 0; m_addr = BASE; m_cnt = 0;
            for (int i = 0; i < 4; i++) m_byte[i] = 8'h00;
        end else if (m_pending) begin
            if (mem_wr_ready) begin
                m_pending = 0;
                m_cnt     = (m_cnt + 1) % 65536;
                m_addr    = (m_addr == (1 << AW) - 1) ? BASE : m_addr + 1;
            end
        end else if (exp_rd) begin
            m_byte[m_n] = data_in;
            if (m_n == 3) begin
                m_n = 0; m_pending = 1;
            end else begin
                m_n = m_n + 1;
            end
        end
        pop_pending = exp_rd;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1; enable = 1'b0; mem_wr_ready = 1'b1; hold_empty = 1'b0;
        apply_src();
        run(3);
        reset = 1'b0;
        chk("rst_valid", 32'(mem_wr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ww", 32'(words_written), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);

        // Basic word with the memory always ready.
        enable = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        run(8);
        chk("w0_ww", 32'(words_written), 32'd1);

        // Memory stalls for five cycles while the write is pending.
        mem_wr_ready = 1'b0;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        wait_valid();
        run(5);
        chk("stall_valid", 32'(mem_wr_valid), 32'd1);
        mem_wr_ready = 1'b1;
        run(3);
        chk("stall_ww", 32'(words_written), 32'd2);

        // Source runs dry after two bytes; partial lanes are held.
        push(8'hAA); push(8'hBB);
        run(3);
        hold_empty = 1'b1; apply_src();
        run(10);
        chk("hold_busy", 32'(busy), 32'd1);
        hold_empty = 1'b0;
        push(8'hCC); push(8'hDD);
        run(6);
        chk("hold_ww", 32'(words_written), 32'd3);

        // Parity word at the top address, then a word that wraps to BASE.
        push(8'h01); push(8'h03); push(8'h07); push(8'h00);
        run(6);
        push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        run(6);
        chk("wrap_ww", 32'(words_written), 32'd5);
        chk("wrap_addr", 32'(mem_addr), 32'd1);

        // enable drops mid-word and again while the write is pending.
        push(8'h9A); push(8'hBC);
        run(3);
        enable = 1'b0;
        push(8'hDE); push(8'hF0);
        run(5);
        chk("en_hold_busy", 32'(busy), 32'd1);
        chk("en_hold_valid", 32'(mem_wr_valid), 32'd0);
        mem_wr_ready = 1'b0;
        enable = 1'b1;
        wait_valid();
        enable = 1'b0;
        run(3);
        chk("en_write_valid", 32'(mem_wr_valid), 32'd1);
        mem_wr_ready = 1'b1;
        run(3);
        chk("en_ww", 32'(words_written), 32'd6);

        // Reset while a write is pending, with ready high in the same cycle.
        enable = 1'b1; mem_wr_ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        wait_valid();
        reset = 1'b1; mem_wr_ready = 1'b1;
        run(1);
        reset = 1'b0;
        chk("rstw_valid", 32'(mem_wr_valid), 32'd0);
        chk("rstw_ww", 32'(words_written), 32'd0);
        chk("rstw_addr", 32'(mem_addr), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        run(8);
        chk("rstw_ww2", 32'(words_written), 32'd1);

        // Hand-computed expectations on the logged writes.
        chk("n_writes", 32'(obs_data.size()), 32'd7);
        if (obs_data.size() >= 7) begin
            chk("wr0_addr", obs_addr[0], 32'd0);
            chk("wr0_data", obs_data[0], 32'h44332211);
            chk("wr1_addr", obs_addr[1], 32'd1);
            chk("wr1_data", obs_data[1], 32'h88776655);
            chk("wr2_addr", obs_addr[2], 32'd2);
            chk("wr2_data", obs_data[2], 32'hDDCCBBAA);
            chk("wr3_addr", obs_addr[3], 32'd3);
            chk("wr3_data", obs_data[3], 32'h00070301);
            chk("wr3_par", 32'(obs_par[3]), 32'h5);
            chk("wr4_addr", obs_addr[4], 32'd0);
            chk("wr4_data", obs_data[4], 32'h78563412);
            chk("wr5_addr", obs_addr[5], 32'd1);
            chk("wr5_data", obs_data[5], 32'hF0DEBC9A);
            chk("wr6_addr", obs_addr[6], 32'd0);
            chk("wr6_data", obs_data[6], 32'hC4C3C2C1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
